// File: rtl/regfile_sb.sv
// Integer register file with a per-register busy scoreboard; x0 is hardwired zero.
// Optional same-cycle write-through and busy release: define REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int WIDTH      = 32,
  parameter int NUM_REGS   = 32,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [WIDTH-1:0]    rd_data,
  input  logic [ADDR_W-1:0]   rs1_addr,
  output logic [WIDTH-1:0]    rs1_data,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic [WIDTH-1:0]    rs2_data,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic                flush,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [NUM_REGS-1:0] busy_vec
);

  if (NUM_REGS != 16 && NUM_REGS != 32) begin : g_bad_num_regs
    $error("regfile_sb: NUM_REGS must be 16 or 32");
  end

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                wr_en;
  logic                iss_en;

  assign wr_en  = wen && (rd_addr != '0);
  assign iss_en = iss_valid && (iss_rd != '0);

  // Later assignments win: flush over issue over writeback; x0 never busy.
  always_comb begin
    busy_nxt = busy_q;
    if (wr_en)  busy_nxt[rd_addr] = 1'b0;
    if (iss_en) busy_nxt[iss_rd]  = 1'b1;
    if (flush)  busy_nxt          = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_en) regs[rd_addr] <= rd_data;
      busy_q <= busy_nxt;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    v = (a == '0) ? '0 : regs[a];
`ifdef REGFILE_BYPASS_EN
    // rst gate keeps reads at zero while the array is held in reset.
    if (rst && wr_en && (rd_addr == a)) v = rd_data;
`endif
    return v;
  endfunction

  function automatic logic busy_port(input logic [ADDR_W-1:0] a);
    logic b;
    b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (rd_addr == a) && !(iss_valid && (iss_rd == a))) b = 1'b0;
`endif
    return b;
  endfunction

  assign rs1_data = read_port(rs1_addr);
  assign rs2_data = read_port(rs2_addr);
  assign rs1_busy = busy_port(rs1_addr);
  assign rs2_busy = busy_port(rs2_addr);
  assign busy_vec = busy_q;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the core's integer register file: NUM_REGS x WIDTH storage, two combinational read ports, one synchronous write port.
- Adds asynchronous clear of all registers and a per-register scoreboard of busy bits: set when an instruction issues with a destination, cleared on writeback, bulk-cleared on flush.
- Sits between decode/issue (reads, busy checks) and writeback (writes, busy clear).
- Register 0 is hardwired zero and never busy.

Parameters:
- WIDTH, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; must be 16 (RV32E) or 32.
- ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wen  in  1  writeback write enable.
- rd_addr  in  ADDR_W  writeback destination index.
- rd_data  in  WIDTH  writeback data.
- rs1_addr  in  ADDR_W  read port 1 index.
- rs1_data  out  WIDTH  read port 1 data.
- rs2_addr  in  ADDR_W  read port 2 index.
- rs2_data  out  WIDTH  read port 2 data.
- iss_valid  in  1  issue strobe: an instruction with a destination is issued this cycle.
- iss_rd  in  ADDR_W  destination index of the issuing instruction.
- flush  in  1  pipeline flush; clears every busy bit.
- rs1_busy  out  1  register at rs1_addr has a write pending.
- rs2_busy  out  1  register at rs2_addr has a write pending.
- busy_vec  out  NUM_REGS  full scoreboard, bit i = register i busy.

Behaviour:
- Reset:
  - rst low immediately clears all registers to 0 and all busy bits to 0, independent of clk.
  - While rst is low, every read returns 0 and every busy output is 0.
  - Deassertion takes effect at the next rising edge; the first write accepted is on that edge.
- Write:
  - On a rising edge with wen=1 and rd_addr!=0, reg[rd_addr] <= rd_data.
  - Write latency is 1 cycle.
  - wen with rd_addr=0 is a no-op.
- Read:
  - Purely combinational from current register state.
  - Index 0 always returns 0.
  - Same-cycle write to the read index returns the old value unless REGFILE_BYPASS_EN is defined (see Optional Feature).
- Scoreboard, at each rising edge, per register i!=0, in priority order:
  1. flush=1: busy[i] <= 0, overriding issue and writeback in the same cycle.
  2. iss_valid=1 and iss_rd==i: busy[i] <= 1. Issue wins over a simultaneous writeback to the same index, since the younger instruction owns the register.
  3. wen=1 and rd_addr==i: busy[i] <= 0.
  4. Otherwise hold.
- busy[0] is constantly 0; iss_valid with iss_rd=0 is a no-op.
- The writeback data write itself is never blocked by flush or by the busy state.
- rs1_busy = busy[rs1_addr], rs2_busy = busy[rs2_addr]. Both combinational and 0 for index 0.
- busy_vec is combinational from the busy flops.
- Writeback to a register that is not busy is legal: data is written, busy stays 0.
- Repeated issue to an already-busy register keeps busy=1 (no counting; in-order single writer).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose index equals rd_addr with wen=1 and rd_addr!=0 returns rd_data in the same cycle (write-through).
  - rsN_busy for that index is forced 0 that cycle unless iss_valid targets the same index.
- Not defined:
  - Reads return stored state only.
  - rsN_busy reflects the flops only.
  - The consumer waits one extra cycle after writeback.

Test Plan:
- Reset and zero register:
  - Stimulus: hold rst=0 mid-run after writing reg5=0xDEADBEEF.
  - Required: rs1_addr=5 reads 0 immediately without a clock edge; busy_vec=0.
  - Stimulus: release reset, write reg0=0x1234.
  - Required: reg0 still reads 0.
- Basic write/read:
  - Stimulus: wen=1, rd_addr=3, rd_data=0xA5A5A5A5; next cycle rs1_addr=3, rs2_addr=3.
  - Required: both ports read 0xA5A5A5A5.
  - Without the macro, the same-edge read returns the old value 0.
- Scoreboard set/clear:
  - Stimulus: iss_valid=1, iss_rd=7 at cycle 0; wen=1, rd_addr=7 at cycle 3.
  - Required: busy_vec[7]=1 and rs1_busy=1 (rs1_addr=7) for cycles 1-3; 0 from cycle 4.
- Simultaneous issue and writeback to the same register:
  - Stimulus: reg9 busy; in one cycle iss_valid=1, iss_rd=9, wen=1, rd_addr=9, rd_data=0x55.
  - Required: reg9=0x55 and busy[9] stays 1.
- Flush priority:
  - Stimulus: busy on regs 2, 4 and 31; flush=1 together with iss_valid=1, iss_rd=4.
  - Required: busy_vec=0 next cycle.
- RV32E variant and bypass:
  - Stimulus: NUM_REGS=16, REGFILE_BYPASS_EN defined; wen=1, rd_addr=15, rd_data=0x0F0F0F0F with rs2_addr=15 in the same cycle.
  - Required: rs2_data=0x0F0F0F0F combinationally; busy_vec width is 16.
